// File: rtl/dorodon_rom_loader.sv
// -----------------------------------------------------------------------------
// dorodon_rom_loader
//
// Bridges the HPS ioctl byte-download stream to the Dorodon core's ROM/PROM
// download port. Bytes whose address is outside the ROM image are dropped.
// Accepted bytes become a one-cycle dn_wr strobe one clock after ioctl_wr.
// A running byte count and modulo-256 checksum are kept for the current (or
// last) download. The core is held in reset from the start of a download
// until SETTLE_CYCLES clocks after it ends.
//
// Parameters
//   LOAD_BYTES     number of valid download bytes (1..65536); addresses at or
//                  above this value are dropped and flag oversize
//   SETTLE_CYCLES  clocks core_reset stays high after the download ends (>=1)
//
// Ports
//   clk_sys         system clock, all logic on its rising edge
//   reset_n         asynchronous active-low reset
//   ioctl_download  download-active level from hps_io
//   ioctl_wr        one-cycle byte-valid strobe
//   ioctl_addr      25-bit byte address
//   ioctl_dout      byte data
//   dn_addr         core download address (holds when dn_wr is low)
//   dn_data         core download data    (holds when dn_wr is low)
//   dn_wr           one-cycle core write strobe
//   core_reset      active-high reset request to the core
//   load_done       download finished and settle period elapsed
//   oversize        sticky: a byte was dropped as out of range
//   byte_count      accepted bytes in the current/last download (saturating)
//   checksum        modulo-256 sum of accepted bytes
// -----------------------------------------------------------------------------
module dorodon_rom_loader #(
    parameter int unsigned LOAD_BYTES    = 32'd49152,
    parameter int unsigned SETTLE_CYCLES = 32'd256
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        oversize,
    output logic [16:0] byte_count,
    output logic [7:0]  checksum
);

    // The settle counter only ever holds values up to SETTLE_CYCLES-1.
    localparam int unsigned      CNT_W       = (SETTLE_CYCLES > 32'd1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

    // The full 25-bit address is compared so that e.g. 0x10000 can never
    // alias onto address 0 of the core.
    localparam logic [24:0] LOAD_LIMIT = 25'(LOAD_BYTES);
    localparam logic [16:0] COUNT_MAX  = 17'h1FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] settle_cnt_r;
    logic [CNT_W-1:0] settle_cnt_next_s;
    logic             dl_q_r;

    logic             dl_rise_s;
    logic             dl_fall_s;
    logic             in_range_s;
    logic             wr_in_load_s;
    logic             accept_s;
    logic             drop_s;

    logic [15:0]      dn_addr_r;
    logic [7:0]       dn_data_r;
    logic             dn_wr_r;
    logic             core_reset_r;
    logic             load_done_r;
    logic             oversize_r;
    logic [16:0]      byte_count_r;
    logic [7:0]       checksum_r;

    logic [15:0]      dn_addr_next_s;
    logic [7:0]       dn_data_next_s;
    logic             dn_wr_next_s;
    logic             oversize_next_s;
    logic [16:0]      byte_count_next_s;
    logic [7:0]       checksum_next_s;

    // Edge detection on the download level and write qualification.
    // ioctl_download itself gates acceptance, so a write coinciding with the
    // falling edge is ignored even though the state is still LOAD.
    always_comb begin
        dl_rise_s    = ioctl_download & ~dl_q_r;
        dl_fall_s    = ~ioctl_download & dl_q_r;
        in_range_s   = (ioctl_addr < LOAD_LIMIT);
        wr_in_load_s = (state_r == ST_LOAD) & ioctl_download & ioctl_wr;
        accept_s     = wr_in_load_s & in_range_s;
        drop_s       = wr_in_load_s & ~in_range_s;
    end

    // Next-state and settle-counter logic. A rising download edge wins over
    // everything else, so a new download aborts SETTLE or leaves RUN at once.
    always_comb begin
        next_state_s      = state_r;
        settle_cnt_next_s = settle_cnt_r;
        if (dl_rise_s) begin
            next_state_s      = ST_LOAD;
            settle_cnt_next_s = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (dl_fall_s) begin
                        next_state_s      = ST_SETTLE;
                        settle_cnt_next_s = SETTLE_LOAD;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == CNT_ZERO) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s      = ST_SETTLE;
                        settle_cnt_next_s = settle_cnt_r - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    next_state_s = ST_RUN;
                end
                default: begin
                    next_state_s      = ST_IDLE;
                    settle_cnt_next_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Next values for the download port, counters and oversize flag.
    always_comb begin
        dn_addr_next_s    = dn_addr_r;
        dn_data_next_s    = dn_data_r;
        dn_wr_next_s      = 1'b0;
        oversize_next_s   = oversize_r;
        byte_count_next_s = byte_count_r;
        checksum_next_s   = checksum_r;
        if (dl_rise_s) begin
            oversize_next_s   = 1'b0;
            byte_count_next_s = 17'd0;
            checksum_next_s   = 8'd0;
        end else if (accept_s) begin
            dn_addr_next_s    = ioctl_addr[15:0];
            dn_data_next_s    = ioctl_dout;
            dn_wr_next_s      = 1'b1;
            checksum_next_s   = checksum_r + ioctl_dout;
            if (byte_count_r == COUNT_MAX) begin
                byte_count_next_s = byte_count_r;
            end else begin
                byte_count_next_s = byte_count_r + 17'd1;
            end
        end else if (drop_s) begin
            oversize_next_s = 1'b1;
        end else begin
            oversize_next_s = oversize_r;
        end
    end

    // State, settle counter and download-level sample registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= CNT_ZERO;
            dl_q_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            settle_cnt_r <= settle_cnt_next_s;
            dl_q_r       <= ioctl_download;
        end
    end

    // Status outputs are registered from the next state so core_reset drops
    // and load_done rises on the same clock that RUN is entered.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_reset_r <= 1'b1;
            load_done_r  <= 1'b0;
        end else begin
            core_reset_r <= (next_state_s != ST_RUN);
            load_done_r  <= (next_state_s == ST_RUN);
        end
    end

    // Download port, counters and oversize flag registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_addr_r    <= 16'd0;
            dn_data_r    <= 8'd0;
            dn_wr_r      <= 1'b0;
            oversize_r   <= 1'b0;
            byte_count_r <= 17'd0;
            checksum_r   <= 8'd0;
        end else begin
            dn_addr_r    <= dn_addr_next_s;
            dn_data_r    <= dn_data_next_s;
            dn_wr_r      <= dn_wr_next_s;
            oversize_r   <= oversize_next_s;
            byte_count_r <= byte_count_next_s;
            checksum_r   <= checksum_next_s;
        end
    end

    assign dn_addr    = dn_addr_r;
    assign dn_data    = dn_data_r;
    assign dn_wr      = dn_wr_r;
    assign core_reset = core_reset_r;
    assign load_done  = load_done_r;
    assign oversize   = oversize_r;
    assign byte_count = byte_count_r;
    assign checksum   = checksum_r;

endmodule
